rf_sb: RTL
==========

// Module: rf_sb
// PURPOSE
//  Parametrised register file for the pipelined core: 2 async read ports, 1 writeback port with
//  4-source write-data select, and a per-register pending-write scoreboard for RAW hazard detection.
//  Sits between decode/issue (reads, issue reservations) and WB (commit).
//  Replaces the single-cycle negedge-write file; all state updates on posedge clk.
// PARAMETERS
//  DATA_W  32  register width
//  ADDR_W  5   index width; depth = 2**ADDR_W
//  PEND_W  2   per-register pending-write counter width; max in-flight writes per reg = 2**PEND_W-1
// PORTS
//  clk        in   1       clock, all updates on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  rR1        in   ADDR_W  read index A
//  rR2        in   ADDR_W  read index B
//  ruse1      in   1       read A is a real source (gates hazard)
//  ruse2      in   1       read B is a real source (gates hazard)
//  rD1        out  DATA_W  read data A (combinational)
//  rD2        out  DATA_W  read data B (combinational)
//  iss_valid  in   1       instruction issues this cycle
//  iss_we     in   1       issuing instruction writes a register
//  iss_wR     in   ADDR_W  issuing instruction destination
//  we         in   1       WB commit
//  wR         in   ADDR_W  WB destination
//  rf_wsel    in   2       wD source: 0 pc4, 1 ext, 2 alu_c, 3 rdo
//  pc4,ext,alu_c,rdo in DATA_W  WB data sources
//  hazard     out  1       issue must stall this cycle
//  err_uflow  out  1       sticky: commit to register with pending count 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): all regs 0, all pend counters 0, err_uflow 0; rD* show 0, hazard 0.
//  - Register 0: reads 0; writes discarded; never pending; issue/commit to r0 ignored by scoreboard.
//  - Write: posedge, if we && wR!=0: regs[wR] <= wD (mux on rf_wsel). Write latency 1 cycle.
//  - Read: rDn = regs[rRn] (0 if rRn==0); see RF_BYPASS_EN for same-cycle commit.
//  - Scoreboard, per reg r!=0, at posedge:
//      inc = iss_valid && iss_we && !hazard && iss_wR==r;  dec = we && wR==r
//      inc&&!dec: pend+1; dec&&!inc: pend-1; both: unchanged; neither: unchanged.
//      dec with pend==0 (and no inc): pend stays 0, err_uflow <= 1 (cleared only by reset).
//  - hazard (comb) = src_busy(1) | src_busy(2) | dst_full, where
//      src_busy(n) = ruse_n && rRn!=0 && pend[rRn]!=0 && !(bypass hit: RF_BYPASS_EN && we &&
//                    wR==rRn && pend[rRn]==1)
//      dst_full    = iss_valid && iss_we && iss_wR!=0 && pend[iss_wR]==2**PEND_W-1
//                    && !(we && wR==iss_wR)
//  - hazard does not depend on iss_valid for source checks; issue stage holds while hazard=1.
//  - Stalled issue (hazard=1) reserves nothing; reservation occurs only on the non-stalled cycle.
//  - Reset mid-operation discards all pending reservations; pipeline is flushed by same reset.
// CONFIGURATION
//  RF_BYPASS_EN defined: write-through; if we && wR!=0 && wR==rRn, rDn = wD same cycle, and
//   the committing reservation no longer raises hazard (pend==1 case above).
//  RF_BYPASS_EN undefined: rDn always the stored value; committed value visible next cycle;
//   a source with pend!=0 stalls through the commit cycle (one extra stall cycle).
// TESTING
//  1 reset: rst_n=0 mid-run with pend[3]=2 -> rD1(r3)=0, pend all 0, hazard=0, err_uflow=0.
//  2 write/read: we=1,wR=5,rf_wsel=2,alu_c=32'hDEAD_BEEF -> next cycle rR1=5 gives 32'hDEAD_BEEF;
//    wR=0 write of 32'h1234 -> rR2=0 reads 0.
//  3 RAW: issue iss_wR=7; next cycle rR1=7,ruse1=1 -> hazard=1; commit wR=7 -> hazard=0 same cycle
//    with RF_BYPASS_EN and rD1=wD; without it hazard=0 only next cycle.
//  4 ruse gate: pend[9]=1, rR2=9, ruse2=0 -> hazard=0.
//  5 full: PEND_W=2, three issues to r4 -> fourth issue hazard=1, pend[4] stays 3; with
//    simultaneous commit wR=4 -> hazard=0, pend[4] stays 3.
//  6 underflow: we=1,wR=6,pend[6]=0 -> reg written, pend 0, err_uflow=1 until rst_n=0.

Source files
------------

// File: rtl/rf_sb.sv
// rtl/rf_sb.sv - register file with 4-source writeback mux and pending-write RAW scoreboard
// Optional feature macro: RF_BYPASS_EN (write-through of the committing value to the read ports)
module rf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  input  logic              ruse1,
  input  logic              ruse2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_wR,
  input  logic              we,
  input  logic [ADDR_W-1:0] wR,
  input  logic [1:0]        rf_wsel,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] ext,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [DATA_W-1:0] rdo,
  output logic              hazard,
  output logic              err_uflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] pend [DEPTH];
  logic [DATA_W-1:0] wd;
  logic              byp1;
  logic              byp2;
  logic              src1_busy;
  logic              src2_busy;
  logic              dst_full;
  logic              inc;
  logic              dec;

  // Writeback data select
  always_comb begin
    wd = pc4;
    case (rf_wsel)
      2'd0:    wd = pc4;
      2'd1:    wd = ext;
      2'd2:    wd = alu_c;
      default: wd = rdo;
    endcase
  end

  // Read port A; r0 is hardwired to zero, optional same-cycle write-through
  always_comb begin
    rD1 = regs[rR1];
    if (rR1 == '0) begin
      rD1 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (we && (wR == rR1)) begin
      rD1 = wd;
    end
`endif
  end

  // Read port B; same policy as port A
  always_comb begin
    rD2 = regs[rR2];
    if (rR2 == '0) begin
      rD2 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (we && (wR == rR2)) begin
      rD2 = wd;
    end
`endif
  end

  // Hazard: a used source still has writes in flight, or the destination counter is saturated
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef RF_BYPASS_EN
    // The last outstanding write is committing now and is forwarded, so no stall is needed
    byp1 = we && (wR == rR1) && (pend[rR1] == PEND_ONE);
    byp2 = we && (wR == rR2) && (pend[rR2] == PEND_ONE);
`endif
    src1_busy = ruse1 && (rR1 != '0) && (pend[rR1] != '0) && !byp1;
    src2_busy = ruse2 && (rR2 != '0) && (pend[rR2] != '0) && !byp2;
    // A commit to the same register frees a slot this cycle, so a full counter can still accept
    dst_full  = iss_valid && iss_we && (iss_wR != '0) && (pend[iss_wR] == PEND_MAX)
                && !(we && (wR == iss_wR));
    hazard    = src1_busy || src2_busy || dst_full;
    inc       = iss_valid && iss_we && !hazard && (iss_wR != '0);
    dec       = we && (wR != '0);
  end

  // Register array write; r0 writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wR != '0)) begin
      regs[wR] <= wd;
    end
  end

  // Pending-write counters: reserve on non-stalled issue, release on commit, flag underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend[i] <= '0;
      end
      err_uflow <= 1'b0;
    end else begin
      if (inc && !(dec && (wR == iss_wR))) begin
        pend[iss_wR] <= pend[iss_wR] + PEND_ONE;
      end
      if (dec && !(inc && (wR == iss_wR))) begin
        if (pend[wR] != '0) begin
          pend[wR] <= pend[wR] - PEND_ONE;
        end else begin
          err_uflow <= 1'b1;
        end
      end
    end
  end

endmodule
